// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall-vector constants, FSM states and redirect defaults
package pipe_ctrl_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // A stall at stage N also holds every stage upstream of it, so each vector is a low-bit mask.
    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallID   = (6'b1 << (STALL_ID + 1)) - 6'd1;
    localparam logic [5:0] StallEX   = (6'b1 << (STALL_EX + 1)) - 6'd1;
    localparam logic [5:0] StallMEM  = (6'b1 << (STALL_MEM + 1)) - 6'd1;
    localparam logic [5:0] StallAll  = (6'b1 << STALL_WB) | StallMEM;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        FLUSH  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000e;
    localparam logic [31:0] ZERO32         = 32'h0000_0000;

    function automatic logic [5:0] stall_encode(input logic exc, input logic mem,
                                                input logic ex, input logic id);
        if (exc)      return StallAll;
        else if (mem) return StallMEM;
        else if (ex)  return StallEX;
        else if (id)  return StallID;
        else          return StallNone;
    endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// rtl/pipe_ctrl_watchdog.sv - stall-run watchdog with sticky timeout and saturating stall counter
import pipe_ctrl_pkg::*;

module stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_active,
    input  logic        in_run,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= ZERO32;
        end else begin
            if (stall_active && in_run) begin
                if (wd_cnt != WD_MAX)
                    wd_cnt <= wd_cnt + 1'b1;
                // Set on the edge where the run length becomes STALL_TIMEOUT.
                if (wd_cnt >= WD_MAX - 1'b1)
                    stall_timeout <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (stall_active && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall arbiter and exception freeze/flush sequencer
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int          FLUSH_CYCLES  = 1,
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter logic [31:0] ERET_CODE     = ERET_CODE_DEF,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    pipe_state_e state;
    logic [3:0]  flush_cnt;
    logic        exc_valid;

    assign exc_valid = (excepttype_i != ZERO32);

    always_comb begin
        stall = StallNone;
        if (rst) begin
            case (state)
                RUN:     stall = stall_encode(exc_valid, stallreq_mem, stallreq_ex, stallreq_id);
                FREEZE:  stall = StallAll;
                default: stall = StallNone;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flush     <= 1'b0;
            new_pc    <= ZERO32;
            flush_cnt <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (exc_valid) begin
                        state  <= FREEZE;
                        new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                    end
                end
                FREEZE: begin
                    state     <= FLUSH;
                    flush     <= 1'b1;
                    flush_cnt <= FLUSH_LOAD;
                end
                FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        state     <= RUN;
                        flush     <= 1'b0;
                        flush_cnt <= 4'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall_active  (stall != StallNone),
        .in_run        (state == RUN),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the five-stage core.
- Arbitrates stall requests from ID, EX and MEM into one per-stage stall vector. The pipeline registers (if_id, id_ex, ex_mem, mem_wb) and the PC consume this vector.
- Sequences the exception/ERET flush: freezes the pipe for one cycle, then drives flush plus a redirect PC for a programmable number of cycles.
- Tracks stall duration with a watchdog and a saturating performance counter.

Parameters:
FLUSH_CYCLES, 1, number of cycles flush and new_pc are held (1..15)
EXC_VECTOR, 32'h00000020, redirect target for every non-ERET exception
ERET_CODE, 32'h0000000e, excepttype_i value that denotes ERET
STALL_TIMEOUT, 1024, consecutive stall cycles before stall_timeout is set

Ports:
clk  in  1  single core clock
rst  in  1  asynchronous, active-low reset
stallreq_id  in  1  ID stage requests stall (load-use hazard)
stallreq_ex  in  1  EX stage requests stall (multi-cycle mul/div, madd)
stallreq_mem  in  1  MEM stage requests stall (data bus wait)
excepttype_i  in  32  nonzero = exception committed at MEM this cycle
cp0_epc_i  in  32  EPC value from CP0, used for ERET
stall  out  6  per-stage stall: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
flush  out  1  clear all pipeline registers to NOP
new_pc  out  32  redirect target, valid while flush=1
stall_timeout  out  1  sticky: a stall run exceeded STALL_TIMEOUT
stall_cycles  out  32  saturating count of cycles with stall!=0

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; flush=0; new_pc=0; stall_timeout=0; stall_cycles=0; watchdog=0; flush counter=0.
  - stall=6'b000000 while in reset.
- States: RUN, FREEZE, FLUSH. Encoding comes from the shared package.
- RUN, stall vector (combinational from the current cycle's requests; strict priority):
  - excepttype_i!=0 -> 6'b111111, next state FREEZE. new_pc is captured at this edge: cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
  - else stallreq_mem -> 6'b011111
  - else stallreq_ex -> 6'b001111
  - else stallreq_id -> 6'b000111
  - else 6'b000000
- FREEZE:
  - Lasts exactly 1 cycle.
  - stall=6'b111111, flush=0, all requests ignored.
  - Next state FLUSH; flush counter loads FLUSH_CYCLES.
- FLUSH:
  - flush=1 (registered, asserted from the first FLUSH cycle); stall=6'b000000; new_pc held constant.
  - Counter decrements each cycle. When it reaches 1, the next state is RUN and flush deasserts on the following edge. flush is therefore high for exactly FLUSH_CYCLES cycles.
  - Exceptions and stall requests arriving during FREEZE or FLUSH are dropped. The flushed stages regenerate any real requests afterwards.
- new_pc: registered; changes only on the RUN->FREEZE transition.
- Watchdog:
  - Counts consecutive cycles with stall!=0 in RUN. Resets to 0 on any cycle with stall==0 or state!=RUN.
  - When the count reaches STALL_TIMEOUT, stall_timeout is set. It stays set until reset; there is no other clear.
- stall_cycles: +1 on every cycle with stall!=0, any state. Saturates at 32'hFFFFFFFF with no wrap.
- Reset mid-FLUSH: immediately returns to RUN with flush=0. No residual redirect.
- Back-to-back: an exception in the first RUN cycle after FLUSH is accepted normally. There is no dead cycle.

Decomposition:
- Shared package/defines: stall-vector bit positions and the 6-bit constants (StallNone, StallID, StallEX, StallMEM, StallAll); FSM state encodings; EXC_VECTOR and ERET_CODE defaults; the 32-bit zero constant.
- One natural sub-module: stall_watchdog (watchdog counter, sticky timeout, saturating stall_cycles counter). The parent keeps the FSM, priority encoder and new_pc register.

Test Plan:
1. Reset release, all requests 0 -> stall=000000, flush=0, new_pc=0, stall_cycles=0.
2. stallreq_id and stallreq_mem high together for 3 cycles -> stall=011111 each cycle, then 000000; stall_cycles=3.
3. excepttype_i=32'h00000008 for 1 cycle while stallreq_ex=1 -> that cycle stall=111111; next cycle FREEZE stall=111111, flush=0; next cycle flush=1, new_pc=32'h00000020, stall=000000; then flush=0 (FLUSH_CYCLES=1).
4. excepttype_i=32'h0000000e, cp0_epc_i=32'h80001234, FLUSH_CYCLES=3 -> flush high exactly 3 cycles, new_pc=32'h80001234. A second exception injected during FLUSH is ignored and new_pc is unchanged.
5. STALL_TIMEOUT=8, stallreq_ex held 8 cycles -> stall_timeout=1 after the 8th stall cycle; it stays 1 after the request drops. Holding 7 cycles, dropping 1, then 7 again -> stall_timeout stays 0.
6. rst asserted during the 2nd cycle of a 3-cycle FLUSH -> flush=0 and new_pc=0 immediately, without waiting for clk; after release, state=RUN and stall=000000.
